// File: rtl/posit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | posit_pkg : shared helpers and types for the carry-save datapath         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package posit_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csa_res_state_e;

endpackage
`default_nettype wire

// File: rtl/csa_chunk_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_chunk_adder : combinational CHUNK-bit adder with carry in/out        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module csa_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o
);

  always_comb begin
    {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};
  end

endmodule
`default_nettype wire

// File: rtl/csa_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_resolver : resolves a (sum, carry) pair to binary, CHUNK bits/cycle  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module csa_resolver
  import posit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (clog2(NUM_CHUNKS) < 1) ? 1 : clog2(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_chunk_check
      $error("csa_resolver: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  csa_res_state_e                   state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             cy_q, cy_d;
  logic                             cout_q, cout_d;
  logic [NUM_CHUNKS-1:0][CHUNK-1:0] sum_q, sum_d;
  logic [NUM_CHUNKS-1:0][CHUNK-1:0] car_q, car_d;
  logic [NUM_CHUNKS-1:0][CHUNK-1:0] res_q, res_d;
  logic [CHUNK-1:0]                 add_s;
  logic                             add_co;

  csa_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a_i  (sum_q[idx_q]),
    .b_i  (car_q[idx_q]),
    .ci_i (cy_q),
    .s_o  (add_s),
    .co_o (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    sum_d   = sum_q;
    car_d   = car_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = RUN;
          sum_d   = sum_i;
          car_d   = carry_i;
          idx_d   = '0;
          cy_d    = 1'b0;
          res_d   = '0;
        end
      end
      RUN: begin
        // One chunk per edge; the chunk carry ripples through cy_q.
        res_d[idx_q] = add_s;
        cy_d         = add_co;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      sum_q   <= '0;
      car_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      sum_q   <= sum_d;
      car_q   <= car_d;
      res_q   <= res_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign result_o    = res_q;
  assign cout_o      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_csa_resolver : directed and randomized checks against (sum+carry)     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_csa_resolver;

  localparam int NC = 4;

  logic        clk, rst_n;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cout, a_busy;
  logic [15:0] a_sum, a_carry, a_result;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cout, b_busy;
  logic [7:0]  b_sum, b_carry, b_result;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  csa_resolver #(.WIDTH(16), .CHUNK(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .sum_i(a_sum), .carry_i(a_carry), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .result_o(a_result), .cout_o(a_cout), .busy_o(a_busy)
  );

  csa_resolver #(.WIDTH(8), .CHUNK(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .sum_i(b_sum), .carry_i(b_carry), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .result_o(b_result), .cout_o(b_cout), .busy_o(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge back in IDLE.
  task automatic run_op(input string tag, input logic [15:0] s, input logic [15:0] c,
                        input int hold);
    logic [16:0] expv;
    int lat;
    expv = {1'b0, s} + {1'b0, c};
    a_sum = s; a_carry = c; a_in_valid = 1'b1; a_out_ready = 1'b0;
    chk({tag, "_rdy"}, 32'(a_in_ready), 32'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_sum = 16'($urandom); a_carry = 16'($urandom);
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (a_out_valid || lat >= 20) break;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(NC));
    chk({tag, "_res"}, 32'(a_result), 32'(expv[15:0]));
    chk({tag, "_cout"}, 32'(a_cout), 32'(expv[16]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'($urandom_range(0, 1));
      a_sum = 16'($urandom);
      @(negedge clk);
      chk({tag, "_hold_ov"}, 32'(a_out_valid), 32'd1);
      chk({tag, "_hold_res"}, 32'(a_result), 32'(expv[15:0]));
      chk({tag, "_hold_rdy"}, 32'(a_in_ready), 32'd0);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_ov"}, 32'(a_out_valid), 32'd0);
    chk({tag, "_post_rdy"}, 32'(a_in_ready), 32'd1);
  endtask

  logic [16:0] q[$];
  logic [16:0] e;
  int          ops, acc_edge, lat;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_sum = '0; a_carry = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_sum = '0; b_carry = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(a_in_ready), 32'd1);
    chk("rst_ov", 32'(a_out_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_res", 32'(a_result), 32'd0);
    chk("rst_cout", 32'(a_cout), 32'd0);
    chk("rst_b_rdy", 32'(b_in_ready), 32'd1);
    rst_n = 1'b1;

    run_op("t1", 16'h00FF, 16'h0001, 0);
    run_op("t2", 16'hFFFF, 16'h0001, 0);
    run_op("t3", 16'hABCD, 16'h7777, 10);

    // Abort mid-operation with reset after two RUN edges.
    a_sum = 16'hAAAA; a_carry = 16'h5555; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_ov", 32'(a_out_valid), 32'd0);
    chk("t4_rdy", 32'(a_in_ready), 32'd1);
    chk("t4_busy", 32'(a_busy), 32'd0);
    chk("t4_res", 32'(a_result), 32'd0);
    for (int i = 0; i < NC + 2; i++) begin
      @(negedge clk);
      chk("t4_no_result", 32'(a_out_valid), 32'd0);
    end
    run_op("t4_next", 16'h1234, 16'h4321, 0);

    // Single-chunk configuration.
    b_sum = 8'h80; b_carry = 8'h80; b_in_valid = 1'b1;
    chk("t5_rdy", 32'(b_in_ready), 32'd1);
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_sum = 8'($urandom); b_carry = 8'($urandom);
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (b_out_valid || lat >= 20) break;
      @(posedge clk); #1;
      lat++;
    end
    chk("t5_lat", 32'(lat), 32'd1);
    chk("t5_res", 32'(b_result), 32'h00);
    chk("t5_cout", 32'(b_cout), 32'd1);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    @(negedge clk);
    chk("t5_post_ov", 32'(b_out_valid), 32'd0);

    // Randomized traffic: model holds at most one outstanding op and its accept edge.
    ops = 0; acc_edge = 0;
    while (ops < 1000 && cyc < 60000) begin
      @(negedge clk);
      chk("rnd_ov", 32'(a_out_valid), 32'((q.size() != 0) && (cyc >= acc_edge + NC)));
      chk("rnd_rdy", 32'(a_in_ready), 32'(q.size() == 0));
      chk("rnd_busy", 32'(a_busy), 32'(q.size() != 0));
      if (a_out_valid && a_out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("rnd_res", 32'(a_result), 32'(e[15:0]));
        chk("rnd_cout", 32'(a_cout), 32'(e[16]));
        ops++;
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back({1'b0, a_sum} + {1'b0, a_carry});
        acc_edge = cyc + 1;
      end
      @(posedge clk); #1;
      a_in_valid  = ($urandom_range(0, 2) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_sum       = 16'($urandom);
      a_carry     = 16'($urandom);
    end
    chk("rnd_ops_done", 32'(ops), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
